// File: rtl/sram_ctrl.sv
// sram_ctrl: initiator-side controller for a single-port synchronous SRAM.
// It clears the whole array to INIT_VAL after every reset. It then turns
// valid/ready requests into SRAM cycles and returns read data on a valid/ready
// response channel, hiding the SRAM's one-cycle registered read latency.
module sram_ctrl #(
    parameter int              AW       = 4,
    parameter int              DW       = 8,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic          REQ_WR,
    input  logic [AW-1:0] REQ_ADDR,
    input  logic [DW-1:0] REQ_WDATA,
    output logic          RSP_VALID,
    input  logic          RSP_READY,
    output logic [DW-1:0] RSP_RDATA,
    output logic          INIT_DONE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    output logic          MEM_WREN,
    input  logic [DW-1:0] MEM_RDATA
);

    localparam int          DEPTH    = 1 << AW;
    // The counter is one bit wider than the address so it can reach DEPTH,
    // which marks the edge after the last init write.
    localparam logic [AW:0] INIT_END = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        RD_ISSUE,
        RD_CAPTURE
    } state_t;

    state_t      state;
    logic [AW:0] init_cnt;
    logic        req_fire;

    // A request is accepted only when idle, initialised and no response is pending.
    assign REQ_READY = INIT_DONE && (state == IDLE) && !RSP_VALID;
    assign req_fire  = REQ_VALID && REQ_READY;

    // Main FSM: array clear, request issue, read capture and response hold.
    // NOTE: all state and outputs here use non-blocking assignments. Every
    // register then samples pre-edge values, which avoids simulation races.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= INIT;
            init_cnt  <= '0;
            INIT_DONE <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= INIT_VAL;
            MEM_WREN  <= 1'b0;
        end else begin
            // A write strobe lasts one cycle unless a branch below re-arms it.
            MEM_WREN <= 1'b0;

            if (RSP_VALID && RSP_READY) begin
                RSP_VALID <= 1'b0;
            end

            case (state)
                INIT: begin
                    if (init_cnt == INIT_END) begin
                        INIT_DONE <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        MEM_ADDR  <= init_cnt[AW-1:0];
                        MEM_WDATA <= INIT_VAL;
                        MEM_WREN  <= 1'b1;
                        init_cnt  <= init_cnt + 1'b1;
                    end
                end

                IDLE: begin
                    if (req_fire) begin
                        MEM_ADDR <= REQ_ADDR;
                        if (REQ_WR) begin
                            // Writes are posted and leave the FSM in IDLE, so
                            // back-to-back writes run at one per cycle.
                            MEM_WDATA <= REQ_WDATA;
                            MEM_WREN  <= 1'b1;
                        end else begin
                            state <= RD_ISSUE;
                        end
                    end
                end

                // The SRAM registers the read data on this edge.
                RD_ISSUE: begin
                    state <= RD_CAPTURE;
                end

                RD_CAPTURE: begin
                    RSP_RDATA <= MEM_RDATA;
                    RSP_VALID <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule
